// File: rtl/mac_receiver_if.sv
// mac_receiver_if: PHY receive stream, RX FIFO write port and per-frame status of the MAC receiver.
interface mac_receiver_if;
    logic [7:0]  rxd;
    logic        rxdv;
    logic        rxer;
    logic        fifo_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        frame_start;
    logic        frame_done;
    logic        frame_good;
    logic        crc_err;
    logic        len_err;
    logic        phy_err;
    logic [10:0] rx_len;
    logic [2:0]  mac_rx_state;
    modport slave (
        input  rxd, rxdv, rxer, fifo_full,
        output wr_en, wr_data, frame_start, frame_done, frame_good,
               crc_err, len_err, phy_err, rx_len, mac_rx_state
    );
    modport master (
        output rxd, rxdv, rxer, fifo_full,
        input  wr_en, wr_data, frame_start, frame_done, frame_good,
               crc_err, len_err, phy_err, rx_len, mac_rx_state
    );
endinterface

// File: rtl/mac_receiver.sv
// mac_receiver: Ethernet RX framer; strips preamble/SFD and writes DA..payload through a 4-byte
// delay line so the FCS never reaches the FIFO, then reports CRC/length/PHY status per frame.
module mac_receiver #(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 1514
) (
    input logic clk,
    input logic reset,
    mac_receiver_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DROP = 3'd4;
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);

    logic [2:0]  st;
    logic [31:0] dl;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [31:0] crc_out;
    logic [2:0]  nv;
    logic [10:0] cnt;
    logic        tracked;
    logic        line_full;
    logic        crc_bad;
    logic        len_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // crc_out is byte-swapped so the first FCS byte on the wire lands in [31:24], like the delay line
    always_comb begin
        line_full = nv[2];
        crc_nxt = crc_byte(crc, dl[31:24]);
        crc_out = ~{crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
        crc_bad = !line_full || dl != crc_out;
        len_bad = cnt < MIN_LEN || cnt > MAX_LEN;
    end

    assign bus.mac_rx_state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            dl <= '0;
            crc <= '1;
            nv <= '0;
            cnt <= '0;
            tracked <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.wr_data <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_good <= 1'b0;
            bus.crc_err <= 1'b0;
            bus.len_err <= 1'b0;
            bus.phy_err <= 1'b0;
            bus.rx_len <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_done <= 1'b0;
            case (st)
                IDLE: begin
                    crc <= '1;
                    if (bus.rxdv && bus.rxd == 8'h55) st <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (!bus.rxdv) st <= IDLE;
                    else if (bus.rxd == 8'hD5) begin
                        st <= DATA;
                        bus.frame_start <= 1'b1;
                        tracked <= 1'b1;
                        bus.frame_good <= 1'b0;
                        bus.crc_err <= 1'b0;
                        bus.len_err <= 1'b0;
                        bus.phy_err <= 1'b0;
                        bus.rx_len <= '0;
                        cnt <= '0;
                        dl <= '0;
                        nv <= '0;
                        crc <= '1;
                    end else if (bus.rxd != 8'h55) begin
                        st <= DROP;
                        tracked <= 1'b0;
                    end
                end
                DATA: begin
                    if (bus.rxer) begin
                        st <= DROP;
                        bus.phy_err <= 1'b1;
                    end else if (!bus.rxdv) st <= CHECK;
                    else if (line_full && bus.fifo_full) begin
                        st <= DROP;
                        bus.phy_err <= 1'b1;
                    end else if (line_full && cnt >= MAX_LEN) begin
                        st <= DROP;
                        bus.len_err <= 1'b1;
                    end else begin
                        dl <= {dl[23:0], bus.rxd};
                        if (line_full) begin
                            bus.wr_en <= 1'b1;
                            bus.wr_data <= dl[31:24];
                            crc <= crc_nxt;
                            cnt <= cnt + 11'(cnt != '1);
                        end else nv <= nv + 3'd1;
                    end
                end
                CHECK: begin
                    st <= IDLE;
                    tracked <= 1'b0;
                    bus.frame_done <= 1'b1;
                    bus.crc_err <= crc_bad;
                    bus.len_err <= len_bad;
                    bus.frame_good <= !(crc_bad || len_bad || bus.phy_err);
                    bus.rx_len <= cnt;
                end
                DROP: begin
                    if (!bus.rxdv) begin
                        st <= IDLE;
                        tracked <= 1'b0;
                        if (tracked) begin
                            bus.frame_done <= 1'b1;
                            bus.frame_good <= 1'b0;
                            bus.rx_len <= cnt;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_receiver.sv
// tb_mac_receiver: directed frames against a frame-level model (expected write stream and status
// per frame), checked every cycle by one compare process, plus literal pins on key results.
module tb_mac_receiver;
    logic clk = 1'b0;
    logic reset;
    mac_receiver_if bus();

    mac_receiver dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        good;
        logic        crc;
        logic        len;
        logic        phy;
        logic [10:0] rx_len;
    } st_t;

    logic [7:0] exp_wr[$];
    st_t        exp_st[$];
    int chk = 0, errs = 0;
    int cyc = 0, last_dv = 0, done_lat = 0;
    int nwr = 0, act_fs = 0, exp_fs = 0;
    logic ff_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    always @(negedge clk) begin
        st_t s;
        if (bus.wr_en) begin
            nwr++;
            check("wr_while_full", 32'(ff_prev), 0);
            check("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) check("wr_data", 32'(bus.wr_data), 32'(exp_wr.pop_front()));
        end
        if (bus.frame_start) act_fs++;
        if (bus.frame_done) begin
            done_lat = cyc - last_dv;
            check("done_expected", 32'(exp_st.size() != 0), 1);
            if (exp_st.size() != 0) begin
                s = exp_st.pop_front();
                check("frame_good", 32'(bus.frame_good), 32'(s.good));
                check("crc_err", 32'(bus.crc_err), 32'(s.crc));
                check("len_err", 32'(bus.len_err), 32'(s.len));
                check("phy_err", 32'(bus.phy_err), 32'(s.phy));
                check("rx_len", 32'(bus.rx_len), 32'(s.rx_len));
            end
        end
        if (bus.rxdv) last_dv = cyc;
        ff_prev = bus.fifo_full;
    end

    task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic ff);
        @(posedge clk);
        #1;
        bus.rxd = d;
        bus.rxdv = dv;
        bus.rxer = er;
        bus.fifo_full = ff;
    endtask

    task automatic idle_and_drain(input string tag);
        repeat (8) drive(8'h00, 1'b0, 1'b0, 1'b0);
        check({tag, "_wr_drained"}, 32'(exp_wr.size()), 0);
        check({tag, "_done_drained"}, 32'(exp_st.size()), 0);
        check({tag, "_frame_starts"}, 32'(act_fs), 32'(exp_fs));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        check({tag, "_frame_start"}, 32'(bus.frame_start), 0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        check({tag, "_frame_good"}, 32'(bus.frame_good), 0);
        check({tag, "_crc_err"}, 32'(bus.crc_err), 0);
        check({tag, "_len_err"}, 32'(bus.len_err), 0);
        check({tag, "_phy_err"}, 32'(bus.phy_err), 0);
        check({tag, "_rx_len"}, 32'(bus.rx_len), 0);
        check({tag, "_state"}, 32'(bus.mac_rx_state), 0);
    endtask

    // err_at: stream index where rxer pulses (or fifo_full rises when use_full); -1 for none
    task automatic run_frame(input string tag, input int ndata, input int err_at, input bit use_full, input bit bad_fcs);
        logic [7:0] s[$];
        logic [31:0] c;
        int L, nw;
        st_t e;
        s = {};
        for (int i = 0; i < ndata; i++) s.push_back(8'(i));
        c = crc32(s, ndata);
        s.push_back(c[7:0]);
        s.push_back(c[15:8]);
        s.push_back(c[23:16]);
        s.push_back(c[31:24]);
        if (bad_fcs) s[s.size() - 1] = s[s.size() - 1] ^ 8'h01;
        L = s.size();
        if (err_at >= 0) begin
            nw = err_at - 4;
            e.good = 1'b0;
            e.crc = 1'b0;
            e.len = 1'b0;
            e.phy = 1'b1;
        end else begin
            nw = L - 4;
            e.crc = crc32(s, nw) != {s[L - 1], s[L - 2], s[L - 3], s[L - 4]};
            e.len = nw < 60 || nw > 1514;
            e.phy = 1'b0;
            e.good = !(e.crc || e.len);
        end
        e.rx_len = 11'(nw);
        for (int i = 0; i < nw; i++) exp_wr.push_back(s[i]);
        exp_st.push_back(e);
        exp_fs++;
        nwr = 0;
        repeat (7) drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'hD5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < L; i++)
            drive(s[i], 1'b1, !use_full && i == err_at, use_full && err_at >= 0 && i >= err_at);
        idle_and_drain(tag);
    endtask

    initial begin
        logic [7:0] t[$];
        int fs0;
        reset = 1'b1;
        bus.rxd = 8'h00;
        bus.rxdv = 1'b0;
        bus.rxer = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        t = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("crc_model_pin", crc32(t, 9), 32'hCBF43926);

        run_frame("good60", 60, -1, 1'b0, 1'b0);
        check("good60_nwr", 32'(nwr), 60);
        check("good60_rx_len", 32'(bus.rx_len), 60);
        check("good60_good", 32'(bus.frame_good), 1);
        check("good60_done_latency", 32'(done_lat), 3);

        run_frame("badfcs", 60, -1, 1'b0, 1'b1);
        check("badfcs_nwr", 32'(nwr), 60);
        check("badfcs_crc_err", 32'(bus.crc_err), 1);
        check("badfcs_good", 32'(bus.frame_good), 0);

        run_frame("short20", 20, -1, 1'b0, 1'b0);
        check("short20_len_err", 32'(bus.len_err), 1);
        check("short20_rx_len", 32'(bus.rx_len), 20);

        run_frame("rxer30", 100, 30, 1'b0, 1'b0);
        check("rxer30_nwr", 32'(nwr), 26);
        check("rxer30_phy_err", 32'(bus.phy_err), 1);

        run_frame("full10", 60, 10, 1'b1, 1'b0);
        check("full10_nwr", 32'(nwr), 6);
        check("full10_phy_err", 32'(bus.phy_err), 1);
        check("full10_good", 32'(bus.frame_good), 0);

        // bad preamble: D5 after the bad byte must not start a frame
        fs0 = act_fs;
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'h12, 1'b1, 1'b0, 1'b0);
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'hD5, 1'b1, 1'b0, 1'b0);
        drive(8'hAA, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("badpre_state", 32'(bus.mac_rx_state), 4);
        idle_and_drain("badpre");
        check("badpre_no_start", 32'(act_fs), 32'(fs0));

        // reset while data byte 40 is on the wire: bytes 0..35 already written
        exp_fs++;
        for (int i = 0; i < 36; i++) exp_wr.push_back(8'(i));
        repeat (7) drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'hD5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(8'(i), 1'b1, 1'b0, 1'b0);
        drive(8'd40, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("midreset");
        drive(8'd41, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        drive(8'd42, 1'b1, 1'b0, 1'b0);
        idle_and_drain("midreset");

        run_frame("after_reset", 60, -1, 1'b0, 1'b0);
        check("after_reset_good", 32'(bus.frame_good), 1);
        check("after_reset_nwr", 32'(nwr), 60);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end
endmodule
